keypad_debounce: RTL and testbench
==================================

Name: keypad_debounce

Overview:
- Conditions the 12 raw keypad buttons (BTN1..BTN9, BTN_star, BTN_0, BTN_sharp) before they reach the 12-to-4 encoder, accumulator and event logic.
- Per key: synchronises, debounces and produces a clean level plus one-cycle press/release strobes.
- Also emits an encoded "new press" code with a multi-press flag, so downstream stores and playback see exactly one event per physical press.

Parameters:
N_KEYS, 12, number of key inputs; bit i is key i (0=BTN1 … 9=BTN_star, 10=BTN_0, 11=BTN_sharp)
SYNC_STAGES, 2, flip-flops in each input synchroniser (legal range 2..4)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a change (legal range 2..2^20)
ACTIVE_HIGH, 1, 1: raw pressed = 1; 0: raw input is inverted before synchronising

Ports:
CLK  input  1  system clock
RST  input  1  synchronous active-high reset
key_raw  input  N_KEYS  asynchronous raw button levels
key_level  output  N_KEYS  debounced level, 1 = pressed
key_press  output  N_KEYS  one-cycle strobe on debounced 0->1
key_release  output  N_KEYS  one-cycle strobe on debounced 1->0
press_valid  output  1  one-cycle strobe: at least one key_press bit set this cycle
press_code  output  4  index of lowest-numbered key in key_press; held between strobes
multi_press  output  1  qualifies press_valid: >1 key_press bit set in same cycle

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST). All state updates on the rising edge of CLK. All outputs are registered.
- Reset, applied on any CLK edge with RST=1, including mid-debounce:
  - synchroniser flops = 0 and stable state = 0 for every key
  - all counters = 0
  - key_level = 0, key_press = 0, key_release = 0
  - press_valid = 0, press_code = 0, multi_press = 0
- After RST deasserts, keys already held are reported as presses once they have been stable DEBOUNCE_CYCLES cycles.
- Synchroniser: key_raw (inverted if ACTIVE_HIGH=0) passes through SYNC_STAGES flops; s_i is the last stage.
- Per-key counter, width ceil(log2(DEBOUNCE_CYCLES)):
  - s_i == key_level[i]: counter <= 0.
  - s_i != key_level[i] and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s_i != key_level[i] and counter == DEBOUNCE_CYCLES-1:
    - key_level[i] <= s_i; counter <= 0
    - key_press[i] <= s_i; key_release[i] <= ~s_i
  - Any single-cycle return of s_i to key_level[i] restarts the count (glitch rejection). The counter never wraps.
- Latency: raw change held steady → key_level and strobe change exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples the new raw value.
- key_press and key_release are high for exactly one cycle per accepted transition. They are never both high for the same key.
- Encoded press path:
  - Computed from the next-state press vector in the same cycle, so press_valid/press_code/multi_press align with key_press (no extra latency).
  - press_code = lowest i with a press strobe; priority BTN1 highest.
  - multi_press = 1 only when press_valid=1 and the popcount of press strobes > 1; otherwise 0.
  - press_code keeps its last value when press_valid=0.
  - Keys pressed on different cycles each give their own press_valid strobe.
  - Holding one key does not block others.
- A simultaneous press of key i and release of key j in one cycle is legal. Both strobes are asserted.
- No auto-repeat: a held key produces one key_press only.
- Counters are independent per key. A shared prescaler is not permitted, because it would skew latency between keys.

Test Plan:
1. Params SYNC_STAGES=2, DEBOUNCE_CYCLES=4. Raise key_raw[4] and hold → key_level[4] rises and key_press[4], press_valid=1, press_code=4 pulse for one cycle, 6 edges after first sampling edge; multi_press=0.
2. Same params, key 0. Toggle key_raw[0] 1,1,1,0,1,1,1,1 (bounce after 3 cycles) → no accept before the final run of 4 stable synchronised cycles; exactly one key_press[0].
3. Hold key 4 pressed, then release and hold 0 → key_release[4] single pulse 6 edges later; press_valid stays 0; press_code stays 4.
4. Raise key_raw[11] and key_raw[2] on the same edge → key_press = 12'h804 for one cycle; press_valid=1, press_code=2, multi_press=1.
5. Key 7 counter at 2 (mid-debounce), assert RST one cycle → all outputs 0. With key still held, press strobe arrives 6 edges after the first post-reset sampling edge.
6. ACTIVE_HIGH=0, key_raw=12'hFFF idle, drive bit 9 low → key_press[9], press_code=9 after 6 edges. Held for 100 cycles → no second strobe.

Source files
------------

// File: rtl/keypad_debounce.sv
// Keypad input conditioning: per-key synchroniser, independent debounce counter,
// clean level, press/release strobes and a priority-encoded "new press" event.
module keypad_debounce #(
  parameter int N_KEYS          = 12,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_HIGH     = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              press_valid,
  output logic [3:0]        press_code,
  output logic              multi_press
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]     CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_KEYS-1:0] ONE     = N_KEYS'(1);

  logic [N_KEYS-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]     r_cnt  [N_KEYS];
  logic [CW-1:0]     w_cnt_nxt [N_KEYS];

  logic [N_KEYS-1:0] w_in;
  logic [N_KEYS-1:0] w_s;
  logic [N_KEYS-1:0] w_level_nxt;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_release;
  logic              w_any;
  logic              w_multi;
  logic              w_found;
  logic [3:0]        w_code;

  assign w_in = (ACTIVE_HIGH != 0) ? key_raw : ~key_raw;
  assign w_s  = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '{default: '0};
    end else begin
      r_sync[0] <= w_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  always_comb begin
    w_level_nxt = key_level;
    w_press     = '0;
    w_release   = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_s[i] == key_level[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_MAX) begin
        w_level_nxt[i] = w_s[i];
        w_cnt_nxt[i]   = '0;
        w_press[i]     = w_s[i];
        w_release[i]   = ~w_s[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  // Encoder works on the next-state strobes so the event lines up with key_press.
  always_comb begin
    w_any   = |w_press;
    w_code  = press_code;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (w_press[i] && !w_found) begin
        w_code  = 4'(i);
        w_found = 1'b1;
      end
    end
    // Clearing the lowest set bit leaves something only if more than one bit was set.
    w_multi = w_any && ((w_press & (w_press - ONE)) != '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt       <= '{default: '0};
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      press_valid <= 1'b0;
      press_code  <= '0;
      multi_press <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      key_level   <= w_level_nxt;
      key_press   <= w_press;
      key_release <= w_release;
      press_valid <= w_any;
      press_code  <= w_code;
      multi_press <= w_multi;
    end
  end

endmodule

// File: tb/tb_keypad_debounce.sv
// Scoreboard bench: stimulus queues expected key events, per-instance monitors
// pop and compare whenever a strobe appears.
module tb_keypad_debounce;

  typedef struct {
    logic [11:0] press;
    logic [11:0] rel;
    logic [11:0] level;
    logic        pv;
    logic [3:0]  code;
    logic        multi;
    int          cyc;
  } ev_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] raw_h = '0;
  logic [11:0] raw_l = 12'hFFF;

  logic [11:0] h_level, h_press, h_rel;
  logic        h_pv, h_multi;
  logic [3:0]  h_code;
  logic [11:0] l_level, l_press, l_rel;
  logic        l_pv, l_multi;
  logic [3:0]  l_code;

  int  cyc    = 0;
  int  n_vec  = 0;
  int  n_err  = 0;
  ev_t qh[$];
  ev_t ql[$];
  ev_t eh, el;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  keypad_debounce #(.N_KEYS(12), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_HIGH(1)) dut_h (
    .CLK(CLK), .RST(RST), .key_raw(raw_h), .key_level(h_level), .key_press(h_press),
    .key_release(h_rel), .press_valid(h_pv), .press_code(h_code), .multi_press(h_multi));

  keypad_debounce #(.N_KEYS(12), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_HIGH(0)) dut_l (
    .CLK(CLK), .RST(RST), .key_raw(raw_l), .key_level(l_level), .key_press(l_press),
    .key_release(l_rel), .press_valid(l_pv), .press_code(l_code), .multi_press(l_multi));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(logic [11:0] p, logic [11:0] r, logic [11:0] lv,
                             logic pv, logic [3:0] c, logic m, int t);
    ev_t e;
    e.press = p; e.rel = r; e.level = lv; e.pv = pv; e.code = c; e.multi = m; e.cyc = t;
    return e;
  endfunction

  task automatic chk_idle_h(input string tag);
    chk({tag, "_level"}, 32'(h_level), 32'h0);
    chk({tag, "_press"}, 32'(h_press), 32'h0);
    chk({tag, "_rel"},   32'(h_rel),   32'h0);
    chk({tag, "_pv"},    32'(h_pv),    32'h0);
    chk({tag, "_code"},  32'(h_code),  32'h0);
    chk({tag, "_multi"}, 32'(h_multi), 32'h0);
  endtask

  always @(negedge CLK) begin
    if (h_press != '0 || h_rel != '0 || h_pv) begin
      if (qh.size() == 0) begin
        chk("h_unexpected_strobe", {8'h0, h_press, h_rel}, 32'h0);
      end else begin
        eh = qh.pop_front();
        chk("h_cycle", 32'(cyc),     32'(eh.cyc));
        chk("h_press", 32'(h_press), 32'(eh.press));
        chk("h_rel",   32'(h_rel),   32'(eh.rel));
        chk("h_level", 32'(h_level), 32'(eh.level));
        chk("h_pv",    32'(h_pv),    32'(eh.pv));
        chk("h_code",  32'(h_code),  32'(eh.code));
        chk("h_multi", 32'(h_multi), 32'(eh.multi));
      end
    end
  end

  always @(negedge CLK) begin
    if (l_press != '0 || l_rel != '0 || l_pv) begin
      if (ql.size() == 0) begin
        chk("l_unexpected_strobe", {8'h0, l_press, l_rel}, 32'h0);
      end else begin
        el = ql.pop_front();
        chk("l_cycle", 32'(cyc),     32'(el.cyc));
        chk("l_press", 32'(l_press), 32'(el.press));
        chk("l_rel",   32'(l_rel),   32'(el.rel));
        chk("l_level", 32'(l_level), 32'(el.level));
        chk("l_pv",    32'(l_pv),    32'(el.pv));
        chk("l_code",  32'(l_code),  32'(el.code));
        chk("l_multi", 32'(l_multi), 32'(el.multi));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bounce;
    int k;
    bounce = 8'b1111_0111;

    repeat (3) @(negedge CLK);
    chk_idle_h("rst");
    chk("rst_l_level", 32'(l_level), 32'h0);
    chk("rst_l_code",  32'(l_code),  32'h0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk_idle_h("post_rst");
    chk("post_rst_l_level", 32'(l_level), 32'h0);

    // Press key 4: 6 edges counting the first sampling edge.
    k = cyc; raw_h[4] = 1'b1;
    qh.push_back(mk(12'h010, 12'h000, 12'h010, 1'b1, 4'd4, 1'b0, k + 6));
    repeat (12) @(negedge CLK);

    // Release key 4: release strobe only, code held at 4.
    k = cyc; raw_h[4] = 1'b0;
    qh.push_back(mk(12'h000, 12'h010, 12'h000, 1'b0, 4'd4, 1'b0, k + 6));
    repeat (12) @(negedge CLK);
    chk("held_code_after_release", 32'(h_code), 32'd4);

    // Bounce on key 0: accepted 6 edges after the last 0->1 raw change.
    k = cyc;
    qh.push_back(mk(12'h001, 12'h000, 12'h001, 1'b1, 4'd0, 1'b0, k + 10));
    for (int j = 0; j < 8; j++) begin
      raw_h[0] = bounce[j];
      @(negedge CLK);
    end
    repeat (10) @(negedge CLK);

    // Keys 11 and 2 together.
    k = cyc; raw_h[11] = 1'b1; raw_h[2] = 1'b1;
    qh.push_back(mk(12'h804, 12'h000, 12'h805, 1'b1, 4'd2, 1'b1, k + 6));
    repeat (12) @(negedge CLK);

    // Release key 0 while pressing key 5 in the same cycle.
    k = cyc; raw_h[0] = 1'b0; raw_h[5] = 1'b1;
    qh.push_back(mk(12'h020, 12'h001, 12'h824, 1'b1, 4'd5, 1'b0, k + 6));
    repeat (12) @(negedge CLK);

    // Key 7 mid-debounce (count 2) when reset hits; held keys re-reported after reset.
    k = cyc; raw_h[7] = 1'b1;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_idle_h("mid_rst");
    qh.push_back(mk(12'h8A4, 12'h000, 12'h8A4, 1'b1, 4'd2, 1'b1, k + 11));
    repeat (14) @(negedge CLK);
    chk("held_code_after_rst", 32'(h_code), 32'd2);

    // Active-low instance: bit 9 driven low, held with no auto-repeat.
    k = cyc; raw_l[9] = 1'b0;
    ql.push_back(mk(12'h200, 12'h000, 12'h200, 1'b1, 4'd9, 1'b0, k + 6));
    repeat (106) @(negedge CLK);
    chk("l_level_held", 32'(l_level), 32'h200);
    chk("l_code_held",  32'(l_code),  32'd9);
    chk("qh_drained", 32'(qh.size()), 32'd0);
    chk("ql_drained", 32'(ql.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
